// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths and the hard-wired zero register.
package cpu_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered count of set bits.
// A reservation beats a same-cycle write to the same register (the new producer wins).
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int CNT_W    = ADDR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    pending_cnt
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                set_new;
  logic                clr_old;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    pending_d = pending_q;
    set_new   = set_en && !pending_q[set_addr];
    clr_old   = clr_en && pending_q[clr_addr] && !(set_en && (set_addr == clr_addr));
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[set_addr] = 1'b1;
    cnt_d = cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
  end

  // NOTE: sequential state uses non-blocking (<=); blocking (=) belongs only in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending     = pending_q;
  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_param_sb.sv
// Two-read, one-write register file with write-through bypass, optional hard-wired r0,
// and a per-register pending-write scoreboard for decode/writeback hazard tracking.
module regfile_param_sb
  import cpu_pkg::*;
#(
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int NUM_REGS    = NUM_REGS_DEF,
  parameter  bit ZERO_REG_EN = 1'b1,
  localparam int ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              rd_busy_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_2,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                wr_ok;
  logic                rsv_ok;

  assign wr_ok  = wr_en  && !(ZERO_REG_EN && (wr_addr  == ZERO_ADDR));
  assign rsv_ok = rsv_en && !(ZERO_REG_EN && (rsv_addr == ZERO_ADDR));

  rf_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (rsv_ok),
    .set_addr    (rsv_addr),
    .clr_en      (wr_ok),
    .clr_addr    (wr_addr),
    .pending     (pending),
    .pending_cnt (pending_cnt)
  );

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_data;
  end

  // NOTE: this array is built from flops, so it can and must be reset; a RAM macro could not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[0] = rd_addr_1;
  assign rd_addr[1] = rd_addr_2;

  // Priority per port: reset / zero register, then same-cycle write bypass, then stored state.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (!rst && !(ZERO_REG_EN && (rd_addr[p] == ZERO_ADDR))) begin
        if (wr_en && (wr_addr == rd_addr[p])) begin
          rd_data[p] = wr_data;
        end else begin
          rd_data[p] = regs_q[rd_addr[p]];
          rd_busy[p] = pending[rd_addr[p]];
        end
      end
    end
  end

  assign rd_data_1 = rd_data[0];
  assign rd_busy_1 = rd_busy[0];
  assign rd_data_2 = rd_data[1];
  assign rd_busy_2 = rd_busy[1];

endmodule

// File: tb/tb_regfile_param_sb.sv
// Scoreboard bench for regfile_param_sb: stimulus pushes model predictions, a monitor
// pops and compares them at the falling edge; directed checks cover the named scenarios.
module tb_regfile_param_sb;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [4:0]  rd_addr_1;
  logic [31:0] rd_data_1;
  logic        rd_busy_1;
  logic [4:0]  rd_addr_2;
  logic [31:0] rd_data_2;
  logic        rd_busy_2;
  logic [5:0]  pending_cnt;

  regfile_param_sb dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .rd_addr_1   (rd_addr_1),
    .rd_data_1   (rd_data_1),
    .rd_busy_1   (rd_busy_1),
    .rd_addr_2   (rd_addr_2),
    .rd_data_2   (rd_data_2),
    .rd_busy_2   (rd_busy_2),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic [5:0]  cnt;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc_idx  = 0;
  logic [31:0] m_mem  [32];
  bit          m_pend [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  // Read semantics: r0 is zero, a same-cycle write is visible, otherwise stored value and busy.
  task automatic model_read(input reg_addr_t a, input logic we, input reg_addr_t wa,
                            input logic [31:0] wd, output logic [31:0] d, output logic b);
    if (a == REG_ZERO)            begin d = '0;       b = 1'b0;      end
    else if (we && (wa == a))     begin d = wd;       b = 1'b0;      end
    else                          begin d = m_mem[a]; b = m_pend[a]; end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic cycle(input logic we, input reg_addr_t wa, input logic [31:0] wd,
                       input logic re, input reg_addr_t ra,
                       input reg_addr_t a1, input reg_addr_t a2);
    exp_t e;
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    rd_addr_1 = a1; rd_addr_2 = a2;
    model_read(a1, we, wa, wd, e.d1, e.b1);
    model_read(a2, we, wa, wd, e.d2, e.b2);
    e.cnt = 6'(model_cnt());
    e.idx = cyc_idx++;
    exp_q.push_back(e);
    if (we && (wa != REG_ZERO)) begin
      m_mem[wa]  = wd;
      m_pend[wa] = 1'b0;
    end
    if (re && (ra != REG_ZERO)) m_pend[ra] = 1'b1;
  endtask

  task automatic idle(input reg_addr_t a1, input reg_addr_t a2);
    cycle(1'b0, '0, '0, 1'b0, '0, a1, a2);
  endtask

  task automatic now_chk(input string n, input logic [31:0] d1, input logic b1,
                         input logic [31:0] d2, input logic b2, input logic [5:0] cnt);
    #2;
    check({n, "_d1"},  64'(rd_data_1),   64'(d1));
    check({n, "_b1"},  64'(rd_busy_1),   64'(b1));
    check({n, "_d2"},  64'(rd_data_2),   64'(d2));
    check({n, "_b2"},  64'(rd_busy_2),   64'(b2));
    check({n, "_cnt"}, 64'(pending_cnt), 64'(cnt));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("mon%0d_d1", e.idx),  64'(rd_data_1),   64'(e.d1));
        check($sformatf("mon%0d_b1", e.idx),  64'(rd_busy_1),   64'(e.b1));
        check($sformatf("mon%0d_d2", e.idx),  64'(rd_data_2),   64'(e.d2));
        check($sformatf("mon%0d_b2", e.idx),  64'(rd_busy_2),   64'(e.b2));
        check($sformatf("mon%0d_cnt", e.idx), 64'(pending_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
    rd_addr_1 = 0; rd_addr_2 = 0;
    model_clear();
    #12 rst = 1'b0;

    // Populate some state so reset has something to clear.
    for (int i = 0; i < 20; i++)
      cycle(1'(i % 2), 5'($urandom_range(1, 31)), $urandom, 1'(i % 3 == 0),
            5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom));
    cycle(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 5'd5, 5'd6);
    idle(5'd5, 5'd0);

    // Asynchronous reset pulse between edges, with a write on the bus that must stay hidden.
    @(posedge clk);
    #1;
    wr_en = 1; wr_addr = 5; wr_data = 32'hFFFF_0000; rd_addr_1 = 5; rd_addr_2 = 0;
    rst = 1'b1;
    #1;
    check("rst_d1",  64'(rd_data_1),   64'h0);
    check("rst_b1",  64'(rd_busy_1),   64'h0);
    check("rst_d2",  64'(rd_data_2),   64'h0);
    check("rst_cnt", 64'(pending_cnt), 64'h0);
    wr_en = 0;
    rst = 1'b0;
    #1;
    check("post_rst_r5", 64'(rd_data_1), 64'h0);
    model_clear();

    cycle(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, 5'd0, 5'd0);
    now_chk("r0_wr", 32'h0, 0, 32'h0, 0, 6'd0);
    idle(5'd0, 5'd0);
    now_chk("r0_rd", 32'h0, 0, 32'h0, 0, 6'd0);

    cycle(1'b1, 5'd3, 32'h1234_5678, 1'b0, '0, 5'd1, 5'd2);
    idle(5'd3, 5'd3);
    now_chk("basic", 32'h1234_5678, 0, 32'h1234_5678, 0, 6'd0);

    cycle(1'b1, 5'd7, 32'h11, 1'b0, '0, 5'd0, 5'd0);
    cycle(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, '0, 5'd7, 5'd0);
    now_chk("bypass", 32'hA5A5_A5A5, 0, 32'h0, 0, 6'd0);
    idle(5'd7, 5'd0);
    now_chk("bypass_after", 32'hA5A5_A5A5, 0, 32'h0, 0, 6'd0);

    cycle(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    now_chk("rsv_same", 32'h0, 0, 32'h0, 0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      idle(5'd9, 5'd0);
      now_chk($sformatf("rsv_idle%0d", i), 32'h0, 1, 32'h0, 0, 6'd1);
    end
    cycle(1'b1, 5'd9, 32'h42, 1'b0, '0, 5'd9, 5'd0);
    now_chk("wb_cycle", 32'h42, 0, 32'h0, 0, 6'd1);
    idle(5'd9, 5'd0);
    now_chk("wb_after", 32'h42, 0, 32'h0, 0, 6'd0);

    cycle(1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd0);
    cycle(1'b1, 5'd4, 32'h99, 1'b1, 5'd4, 5'd4, 5'd0);
    idle(5'd4, 5'd4);
    now_chk("wr_rsv", 32'h99, 1, 32'h99, 1, 6'd1);

    for (int i = 1; i < 32; i++) cycle(1'b0, '0, '0, 1'b1, 5'(i), 5'(i), 5'd0);
    cycle(1'b0, '0, '0, 1'b1, 5'd1, 5'd1, 5'd0);
    cycle(1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd31);
    now_chk("sat", 32'h0, 0, 32'h0, 1, 6'd31);

    // Random traffic focused on a few registers to provoke bypass and set/clear collisions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, ra, a1, a2;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom);
      cycle(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 2) == 0), ra, a1, a2);
    end
    idle(5'd0, 5'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param_sb.md
Name: regfile_param_sb

Overview:
- Parametrised, clocked general-purpose register file with a register-zero option, write-to-read bypass and a per-register pending-write scoreboard.
- Next-generation register file for the pipelined CPU datapath.
- Decode reads operands and reserves its destination register.
- Writeback writes results and releases the reservation.
- Hazard logic stalls on the busy flags.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of registers; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), address width; derived, do not override.
- ZERO_REG_EN, 1, 1 = register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- wr_en  in  1  Write strobe.
- wr_addr  in  ADDR_W  Write destination register.
- wr_data  in  DATA_W  Write data.
- rsv_en  in  1  Reserve strobe: marks the destination as pending.
- rsv_addr  in  ADDR_W  Register to reserve.
- rd_addr_1  in  ADDR_W  Read port 1 address.
- rd_data_1  out  DATA_W  Read port 1 data.
- rd_busy_1  out  1  Read port 1 register has a pending write.
- rd_addr_2  in  ADDR_W  Read port 2 address.
- rd_data_2  out  DATA_W  Read port 2 data.
- rd_busy_2  out  1  Read port 2 register has a pending write.
- pending_cnt  out  ADDR_W+1  Number of registers currently marked pending.

Behaviour:
- Reset: asserting rst clears all registers to 0, all pending bits to 0 and pending_cnt to 0 immediately, with no clock needed. Outputs read 0 / not busy while rst is high. Deasserting rst mid-operation loses all in-flight reservations; this is intended.
- Write:
  - At the clk edge with wr_en=1, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0.
  - The pending bit is not cleared if a reservation to the same address lands in the same cycle (see priority below).
  - With ZERO_REG_EN=1, writes to address 0 are dropped.
- Read: combinational, 0-cycle latency. Per port p:
  - If ZERO_REG_EN=1 and rd_addr_p=0: rd_data_p=0 and rd_busy_p=0.
  - Else if wr_en=1 and wr_addr=rd_addr_p: rd_data_p=wr_data (write-through bypass) and rd_busy_p=0.
  - Else: rd_data_p=reg[rd_addr_p] and rd_busy_p=pending[rd_addr_p].
- Reserve:
  - At the clk edge with rsv_en=1, pending[rsv_addr] <= 1. Ignored for address 0 when ZERO_REG_EN=1.
  - A reservation has no effect on read outputs in the same cycle; the busy flag appears the following cycle.
- Simultaneous events:
  - wr_en and rsv_en to the same address in one cycle: the data is written and the pending bit ends at 1. The new producer wins.
  - Reserving an already-pending register: the bit stays 1 and the count does not change.
  - Writing a non-pending register: data is updated and the count does not change.
  - Both read ports may use the same address; both see identical results.
- pending_cnt:
  - Registered population count of pending bits, updated at the same edge.
  - Next value = cnt + (reserve sets a bit that was 0) - (write clears a bit that was 1).
  - Range 0..NUM_REGS; it cannot wrap because it tracks real bits.
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W_DEF=32 and NUM_REGS_DEF=32;
  - reg_addr_t typedef of logic [4:0];
  - REG_ZERO=0.
- One sub-module, rf_scoreboard, parametrised by NUM_REGS:
  - owns the pending bit-vector, set/clear priority and pending_cnt;
  - exposes the pending vector to the parent, which applies bypass and zero masking.

Test Plan:
- Reset and zero register:
  - Stimulus: rst pulse mid-cycle with no clk edge, then read r5 and r0; then write r0=0xDEADBEEF and read r0.
  - Response: all reads return 0, busy=0 and pending_cnt=0 immediately; after the write, r0 still reads 0 and is not busy.
- Basic write and read:
  - Stimulus: write r3=0x12345678, then next cycle read r3 on both ports.
  - Response: 0x12345678 on both ports, busy=0.
- Bypass:
  - Stimulus: in one cycle wr_en r7=0xA5A5A5A5 with rd_addr_1=7, where r7 previously held 0x11.
  - Response: rd_data_1=0xA5A5A5A5 in the same cycle; after the edge it still reads 0xA5A5A5A5.
- Scoreboard lifecycle:
  - Stimulus: reserve r9, then read r9 while idle for 3 cycles, then write r9=0x42.
  - Response: busy_1=1 for the 3 idle cycles and pending_cnt=1; in the write cycle busy=0 and data=0x42; afterwards pending_cnt=0.
- Simultaneous reserve and write:
  - Stimulus: r4 pending; in one cycle write r4=0x99 and reserve r4.
  - Response: next cycle r4 reads 0x99 with busy=1 and pending_cnt unchanged at 1.
- Count saturation:
  - Stimulus: reserve r1..r31 sequentially, then reserve r1 again and reserve r0.
  - Response: pending_cnt reaches 31 and stays 31; r0 is never busy.
